// File: rtl/sprite_anim_draw.sv
// Animated, scalable, mirrorable sprite drawer for the VGA object layer.
// Three-stage pipeline: coords -> ROM address -> ROM data -> drawing_request/mVGA_RGB.
module sprite_anim_draw #(
    parameter int OBJ_W      = 32,
    parameter int OBJ_H      = 32,
    parameter int NUM_FRAMES = 4,
    parameter int SCALE_LOG2 = 0,
    parameter int FRAME_HOLD = 6,
    parameter int LOOP       = 1,
    parameter int ADDR_W     = $clog2(NUM_FRAMES * OBJ_W * OBJ_H),
    parameter int FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [10:0]       oCoord_X,
    input  logic [10:0]       oCoord_Y,
    input  logic [10:0]       ObjectStartX,
    input  logic [10:0]       ObjectStartY,
    input  logic              startOfFrame,
    input  logic              anim_en,
    input  logic              anim_restart,
    input  logic              flip_x,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [8:0]        rom_data,
    output logic              drawing_request,
    output logic [7:0]        mVGA_RGB,
    output logic [FIDX_W-1:0] frame_idx,
    output logic              anim_done
);

    localparam int          HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int          FRAME_SZ = OBJ_W * OBJ_H;
    localparam logic [11:0] SPAN_X   = 12'(OBJ_W << SCALE_LOG2);
    localparam logic [11:0] SPAN_Y   = 12'(OBJ_H << SCALE_LOG2);

    logic [11:0]       cx, cy, sx, sy, dx, dy, lx, lxf, ly;
    logic              hit;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic              hit_d1_q, hit_d2_q;
    logic              drq_q;
    logic [7:0]        rgb_q;
    logic [FIDX_W-1:0] frame_d, frame_q;
    logic [HOLD_W-1:0] hold_d, hold_q;
    logic              done_d, done_q;

    // 12-bit compare so a sprite straddling X=2047 does not wrap its end bound.
    always_comb begin
        cx  = {1'b0, oCoord_X};
        cy  = {1'b0, oCoord_Y};
        sx  = {1'b0, ObjectStartX};
        sy  = {1'b0, ObjectStartY};
        hit = (cx >= sx) && (cx < sx + SPAN_X) && (cy >= sy) && (cy < sy + SPAN_Y);
        dx  = cx - sx;
        dy  = cy - sy;
        lx  = dx >> SCALE_LOG2;
        ly  = dy >> SCALE_LOG2;
        lxf = flip_x ? (12'(OBJ_W - 1) - lx) : lx;
        rom_addr_d = '0;
        if (hit)
            rom_addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ)
                       + ADDR_W'(ly) * ADDR_W'(OBJ_W) + ADDR_W'(lxf);
    end

    always_comb begin
        frame_d = frame_q;
        hold_d  = hold_q;
        done_d  = done_q;
        if (anim_restart) begin
            frame_d = '0;
            hold_d  = '0;
            done_d  = 1'b0;
        end else if (startOfFrame && anim_en && !done_q) begin
            if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                hold_d = '0;
                if (frame_q == FIDX_W'(NUM_FRAMES - 1)) begin
                    if (LOOP != 0) frame_d = '0;
                    else           done_d  = 1'b1;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rom_addr_q <= '0;
            hit_d1_q   <= 1'b0;
            hit_d2_q   <= 1'b0;
            drq_q      <= 1'b0;
            rgb_q      <= 8'h00;
            frame_q    <= '0;
            hold_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit_d1_q   <= hit;
            hit_d2_q   <= hit_d1_q;
            drq_q      <= hit_d2_q & rom_data[8];
            rgb_q      <= hit_d2_q ? rom_data[7:0] : 8'h00;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr        = rom_addr_q;
    assign drawing_request = drq_q;
    assign mVGA_RGB        = rgb_q;
    assign frame_idx       = frame_q;
    assign anim_done       = done_q;

endmodule
